hls_macc_collect: RTL and testbench
===================================

Name: hls_macc_collect

Overview:
- Downstream result stage for the hls_macc compute core.
- Captures each completed transaction (o1, o2, ap_return1) in the cycle its valid strobes fire, and buffers it in a small first-word-fall-through FIFO.
- Presents buffered results on a valid/ready stream.
- Keeps a running signed sum and count of the ap_return1 values that leave the stage.
- Drives a hold signal back to the core's start controller so no result is ever produced into a full buffer.

Parameters:
- DEPTH, 4: FIFO entries. Power of two, at least 2.
- DW, 32: width of each result field.
- ACC_W, 48: accumulator width. Must be greater than DW.

Ports:
- ap_clk, in, 1: clock. All logic is on the rising edge.
- ap_rst_n, in, 1: reset. Asynchronous, active-low.
- in_vld, in, 1: result strobe from the core. It is the AND of o1_ap_vld, o2_ap_vld and ap_return1_ap_vld, which pulse together for 1 cycle.
- in_o1, in, DW: core o1.
- in_o2, in, DW: core o2.
- in_ret, in, DW: core ap_return1, signed.
- start_hold, out, 1: when 1, the start controller must not raise ap_start.
- m_valid, out, 1: head entry is valid.
- m_ready, in, 1: consumer accepts the head entry.
- m_o1, out, DW: head entry o1.
- m_o2, out, DW: head entry o2.
- m_ret, out, DW: head entry ap_return1.
- acc_clr, in, 1: synchronous clear of the accumulator and counter.
- acc_sum, out, ACC_W: signed running sum of popped m_ret values.
- acc_cnt, out, 16: number of pops since the last clear. Saturates at 16'hFFFF.
- drop_err, out, 1: sticky. Set when a result arrives into a full FIFO.
- acc_sat, out, 1: sticky saturation flag. Exists only with the optional feature; otherwise tied to 0.

Behaviour:
- Reset, applied asynchronously while ap_rst_n is 0:
  - write pointer, read pointer and count are 0;
  - m_valid=0, start_hold=0, acc_sum=0, acc_cnt=0, drop_err=0, acc_sat=0;
  - FIFO storage is not reset.
- Reset asserted mid-operation discards all buffered entries and the accumulator state. Release of ap_rst_n is synchronized by the system.
- Push: when in_vld=1 and the FIFO is not full, {in_o1, in_o2, in_ret} is written at the write pointer at the clock edge. Pointers wrap modulo DEPTH.
- Pop: when m_valid=1 and m_ready=1, the read pointer advances.
- m_valid=(count!=0). m_o1, m_o2 and m_ret come combinationally from the head entry (first-word fall-through).
- Latency: a push into an empty FIFO raises m_valid in the next cycle.
- Push and pop in the same cycle:
  - allowed at any count, including full;
  - count is unchanged;
  - when full, the popped entry leaves and the new entry is stored.
- Push when full with no pop in the same cycle: the entry is discarded and drop_err is set to 1. drop_err clears only on reset.
- start_hold=1 when count >= DEPTH-1, registered from the next-state count.
  - The core can have one transaction in flight (2-cycle latency).
  - This rule guarantees a slot for it, so drop_err never fires with a compliant start controller.
- Accumulator, evaluated at each clock edge:
  - acc_clr=1 and pop: acc_sum = sign-extend(m_ret), acc_cnt=1;
  - acc_clr=1, no pop: acc_sum=0, acc_cnt=0;
  - pop only: acc_sum += sign-extend(m_ret), acc_cnt = min(acc_cnt+1, 16'hFFFF);
  - otherwise: no change.
- The sum wraps modulo 2^ACC_W unless the optional feature is compiled in.
- acc_clr does not affect the FIFO or drop_err.
- There is no state machine beyond the FIFO occupancy. Occupancy states are EMPTY (count=0), PARTIAL, and FULL (count=DEPTH). Transitions follow the push and pop rules above.

Optional Feature:
- Macro: HLS_MACC_COLLECT_ACC_SAT_EN.
- Defined:
  - the accumulate step saturates: positive overflow clamps to 2^(ACC_W-1)-1, negative overflow clamps to -2^(ACC_W-1);
  - any clamp sets acc_sat;
  - acc_sat clears only on acc_clr or reset.
- Undefined: the sum wraps and acc_sat is constant 0.

Test Plan:
- Basic flow: with m_ready=1, one in_vld pulse with o1=5, o2=7, ret=-3 -> next cycle m_valid=1 with fields 5/7/-3; acc_sum=-3 and acc_cnt=1 after the pop.
- Fill: m_ready=0, 3 pushes at DEPTH=4 -> start_hold=1 after the third push. A 4th push (in flight) -> count=4, drop_err stays 0. A 5th push -> entry discarded, drop_err=1, FIFO contents unchanged.
- Full push and pop: FIFO full, in_vld and m_ready both 1 in the same cycle -> count stays 4, drop_err stays 0, order preserved across pointer wrap.
- Clear with pop: acc_sum=100, acc_clr=1 plus a pop of ret=9 in the same cycle -> acc_sum=9, acc_cnt=1.
- Reset mid-operation: 2 entries buffered and acc_sum=50, then ap_rst_n pulsed low asynchronously between edges -> m_valid=0, acc_sum=0 and drop_err=0 immediately, with no edge needed.
- Saturation (macro defined, ACC_W=33): pop ret=32'h7FFFFFFF three times -> acc_sum=2^32-1, acc_sat=1. With the macro undefined, the same stimulus gives acc_sum wrapping to 33'h17FFFFFFD and acc_sat=0.

Source files
------------

// File: rtl/hls_macc_collect_if.sv
// Result-stage bus: core result strobe/fields in, FWFT result stream out, start hold back.
// slave = collect stage, master = the environment driving core results and consuming the stream.
interface hls_macc_collect_if #(
    parameter int DW = 32
);
    logic          in_vld;
    logic [DW-1:0] in_o1;
    logic [DW-1:0] in_o2;
    logic [DW-1:0] in_ret;
    logic          start_hold;
    logic          m_valid;
    logic          m_ready;
    logic [DW-1:0] m_o1;
    logic [DW-1:0] m_o2;
    logic [DW-1:0] m_ret;

    modport slave (
        input  in_vld, in_o1, in_o2, in_ret, m_ready,
        output start_hold, m_valid, m_o1, m_o2, m_ret
    );

    modport master (
        output in_vld, in_o1, in_o2, in_ret, m_ready,
        input  start_hold, m_valid, m_o1, m_o2, m_ret
    );
endinterface

// File: rtl/hls_macc_collect.sv
// Buffers hls_macc results in a FWFT FIFO and accumulates popped ap_return1 values.
// Latency: push into empty FIFO shows m_valid next cycle; head fields are combinational.
// Backpressure: start_hold at count >= DEPTH-1; HLS_MACC_COLLECT_ACC_SAT_EN makes the sum saturate.
module hls_macc_collect #(
    parameter int DEPTH = 4,
    parameter int DW    = 32,
    parameter int ACC_W = 48
) (
    input  logic             ap_clk,
    input  logic             ap_rst_n,
    hls_macc_collect_if.slave bus,
    input  logic             acc_clr,
    output logic [ACC_W-1:0] acc_sum,
    output logic [15:0]      acc_cnt,
    output logic             drop_err,
    output logic             acc_sat
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);
    localparam logic [PW:0] HOLD_CNT = (PW+1)'(DEPTH - 1);

    typedef struct packed {
        logic [DW-1:0] o1;
        logic [DW-1:0] o2;
        logic [DW-1:0] ret;
    } entry_t;

    entry_t          mem_q [DEPTH];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PW:0]     cnt_q, cnt_d;
    logic            hold_q, hold_d;
    logic            drop_q, drop_d;
    logic [ACC_W-1:0] sum_q, sum_d;
    logic [15:0]     acc_cnt_q, acc_cnt_d;

    logic            full;
    logic            pop;
    logic            push_ok;
    entry_t          head;
    logic [ACC_W-1:0] ret_ext;
    logic [ACC_W-1:0] sum_add;
    logic [ACC_W-1:0] sum_step;

    assign full    = (cnt_q == FULL_CNT);
    assign head    = mem_q[rd_ptr_q];
    assign pop     = bus.m_valid && bus.m_ready;
    // A full FIFO still accepts when the head leaves in the same cycle.
    assign push_ok = bus.in_vld && (!full || pop);

    assign bus.m_valid    = (cnt_q != '0);
    assign bus.m_o1       = head.o1;
    assign bus.m_o2       = head.o2;
    assign bus.m_ret      = head.ret;
    assign bus.start_hold = hold_q;

    assign ret_ext = {{(ACC_W-DW){head.ret[DW-1]}}, head.ret};
    assign sum_add = sum_q + ret_ext;

    always_comb begin
        wr_ptr_d = push_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop     ? rd_ptr_q + 1'b1 : rd_ptr_q;
        cnt_d    = cnt_q + (PW+1)'(push_ok) - (PW+1)'(pop);
        hold_d   = (cnt_d >= HOLD_CNT);
        drop_d   = drop_q | (bus.in_vld && full && !pop);
    end

`ifdef HLS_MACC_COLLECT_ACC_SAT_EN
    logic acc_sat_q, acc_sat_d;
    logic ovf_pos, ovf_neg;

    assign ovf_pos  = !sum_q[ACC_W-1] && !ret_ext[ACC_W-1] &&  sum_add[ACC_W-1];
    assign ovf_neg  =  sum_q[ACC_W-1] &&  ret_ext[ACC_W-1] && !sum_add[ACC_W-1];
    assign sum_step = ovf_pos ? {1'b0, {(ACC_W-1){1'b1}}} :
                      ovf_neg ? {1'b1, {(ACC_W-1){1'b0}}} : sum_add;
    assign acc_sat  = acc_sat_q;

    always_comb begin
        acc_sat_d = acc_sat_q;
        if (acc_clr) begin
            acc_sat_d = 1'b0;
        end else if (pop && (ovf_pos || ovf_neg)) begin
            acc_sat_d = 1'b1;
        end
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            acc_sat_q <= 1'b0;
        end else begin
            acc_sat_q <= acc_sat_d;
        end
    end
`else
    assign sum_step = sum_add;
    assign acc_sat  = 1'b0;
`endif

    always_comb begin
        sum_d     = sum_q;
        acc_cnt_d = acc_cnt_q;
        if (acc_clr) begin
            sum_d     = pop ? ret_ext : '0;
            acc_cnt_d = pop ? 16'd1 : 16'd0;
        end else if (pop) begin
            sum_d     = sum_step;
            acc_cnt_d = (acc_cnt_q == 16'hFFFF) ? acc_cnt_q : acc_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            cnt_q     <= '0;
            hold_q    <= 1'b0;
            drop_q    <= 1'b0;
            sum_q     <= '0;
            acc_cnt_q <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            cnt_q     <= cnt_d;
            hold_q    <= hold_d;
            drop_q    <= drop_d;
            sum_q     <= sum_d;
            acc_cnt_q <= acc_cnt_d;
        end
    end

    // Storage carries no reset; occupancy alone decides what is valid.
    always_ff @(posedge ap_clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= '{o1: bus.in_o1, o2: bus.in_o2, ret: bus.in_ret};
        end
    end

    assign acc_sum  = sum_q;
    assign acc_cnt  = acc_cnt_q;
    assign drop_err = drop_q;
endmodule

// File: tb/tb_hls_macc_collect.sv
// Randomized and directed bench for hls_macc_collect against a queue/integer reference model.
module tb_hls_macc_collect;
    localparam int DEPTH = 4;
    localparam int DW    = 32;
    localparam int ACC_W = 33;

    typedef struct {
        logic [DW-1:0] o1;
        logic [DW-1:0] o2;
        logic [DW-1:0] ret;
    } ent_t;

    logic             ap_clk;
    logic             ap_rst_n;
    logic             acc_clr;
    logic [ACC_W-1:0] acc_sum;
    logic [15:0]      acc_cnt;
    logic             drop_err;
    logic             acc_sat;

    hls_macc_collect_if #(.DW(DW)) bus ();

    hls_macc_collect #(.DEPTH(DEPTH), .DW(DW), .ACC_W(ACC_W)) dut (
        .ap_clk   (ap_clk),
        .ap_rst_n (ap_rst_n),
        .bus      (bus),
        .acc_clr  (acc_clr),
        .acc_sum  (acc_sum),
        .acc_cnt  (acc_cnt),
        .drop_err (drop_err),
        .acc_sat  (acc_sat)
    );

    initial ap_clk = 1'b0;
    always #5 ap_clk = ~ap_clk;

    int     checks = 0;
    int     errors = 0;
    ent_t   q[$];
    longint m_sum  = 0;
    int     m_cnt  = 0;
    bit     m_drop = 0;
    bit     m_sat  = 0;

    localparam longint MAXV = (64'sd1 <<< (ACC_W-1)) - 1;
    localparam longint MINV = -(64'sd1 <<< (ACC_W-1));

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_state();
        logic [ACC_W-1:0] es;
        es = m_sum[ACC_W-1:0];
        check("start_hold", bus.start_hold, (q.size() >= DEPTH-1));
        check("m_valid",    bus.m_valid,    (q.size() != 0));
        check("acc_sum",    acc_sum,        es);
        check("acc_cnt",    acc_cnt,        m_cnt[15:0]);
        check("drop_err",   drop_err,       m_drop);
        check("acc_sat",    acc_sat,        m_sat);
    endtask

    // One clock: drive inputs, check the combinational head, advance model, check state.
    task automatic cycle(input bit vld, input logic [DW-1:0] o1, input logic [DW-1:0] o2,
                         input logic [DW-1:0] ret, input bit rdy, input bit clr);
        ent_t   e;
        bit     pop, full;
        longint r;
        bus.in_vld  = vld;
        bus.in_o1   = o1;
        bus.in_o2   = o2;
        bus.in_ret  = ret;
        bus.m_ready = rdy;
        acc_clr     = clr;
        #1;
        check("m_valid_pre", bus.m_valid, (q.size() != 0));
        if (q.size() != 0) begin
            check("head_o1",  bus.m_o1,  q[0].o1);
            check("head_o2",  bus.m_o2,  q[0].o2);
            check("head_ret", bus.m_ret, q[0].ret);
        end
        pop  = (q.size() != 0) && rdy;
        full = (q.size() == DEPTH);
        e    = '{o1: '0, o2: '0, ret: '0};
        if (pop) e = q.pop_front();
        if (vld) begin
            if (!full || pop) q.push_back('{o1: o1, o2: o2, ret: ret});
            else m_drop = 1;
        end
        if (clr) begin
            m_sum = pop ? longint'($signed(e.ret)) : 0;
            m_cnt = pop ? 1 : 0;
            m_sat = 0;
        end else if (pop) begin
            r = m_sum + longint'($signed(e.ret));
`ifdef HLS_MACC_COLLECT_ACC_SAT_EN
            if (r > MAXV) begin r = MAXV; m_sat = 1; end
            else if (r < MINV) begin r = MINV; m_sat = 1; end
`else
            r = (r <<< (64 - ACC_W)) >>> (64 - ACC_W);
`endif
            m_sum = r;
            m_cnt = (m_cnt >= 16'hFFFF) ? 16'hFFFF : m_cnt + 1;
        end
        @(posedge ap_clk);
        #1;
        check_state();
    endtask

    task automatic idle(input bit rdy);
        cycle(1'b0, '0, '0, '0, rdy, 1'b0);
    endtask

    initial begin
        ap_rst_n    = 1'b0;
        bus.in_vld  = 1'b0;
        bus.in_o1   = '0;
        bus.in_o2   = '0;
        bus.in_ret  = '0;
        bus.m_ready = 1'b0;
        acc_clr     = 1'b0;
        #3;
        check("rst_m_valid",    bus.m_valid,    1'b0);
        check("rst_start_hold", bus.start_hold, 1'b0);
        check("rst_acc_sum",    acc_sum,        '0);
        check("rst_acc_cnt",    acc_cnt,        16'd0);
        check("rst_drop_err",   drop_err,       1'b0);
        check("rst_acc_sat",    acc_sat,        1'b0);
        #9 ap_rst_n = 1'b1;
        @(posedge ap_clk);
        #1;

        // Basic flow
        cycle(1'b1, 32'd5, 32'd7, -32'sd3, 1'b1, 1'b0);
        check("basic_valid", bus.m_valid, 1'b1);
        cycle(1'b0, '0, '0, '0, 1'b1, 1'b0);
        check("basic_sum", acc_sum, {ACC_W{1'b1}} - 33'd2);
        check("basic_cnt", acc_cnt, 16'd1);

        // Fill to full, then one push too many
        for (int i = 0; i < 5; i++) cycle(1'b1, $urandom, $urandom, $urandom, 1'b0, 1'b0);
        check("fill_drop", drop_err, 1'b1);
        check("fill_hold", bus.start_hold, 1'b1);

        // Simultaneous push and pop while full, across pointer wrap
        for (int i = 0; i < 6; i++) cycle(1'b1, $urandom, $urandom, $urandom, 1'b1, 1'b0);
        for (int i = 0; i < DEPTH + 1; i++) idle(1'b1);

        // Clear with pop
        cycle(1'b1, 32'd1, 32'd2, 32'd100, 1'b0, 1'b1);
        cycle(1'b1, 32'd3, 32'd4, 32'd9, 1'b1, 1'b0);
        check("pre_clr_sum", acc_sum, 33'd100);
        cycle(1'b0, '0, '0, '0, 1'b1, 1'b1);
        check("clr_pop_sum", acc_sum, 33'd9);
        check("clr_pop_cnt", acc_cnt, 16'd1);

        // Large positive pops: saturation or wrap depending on build
        cycle(1'b1, 32'd0, 32'd0, 32'h7FFFFFFF, 1'b0, 1'b1);
        cycle(1'b1, 32'd0, 32'd0, 32'h7FFFFFFF, 1'b1, 1'b0);
        cycle(1'b1, 32'd0, 32'd0, 32'h7FFFFFFF, 1'b1, 1'b0);
        idle(1'b1);
`ifdef HLS_MACC_COLLECT_ACC_SAT_EN
        check("sat_sum", acc_sum, 33'h0FFFFFFFF);
        check("sat_flag", acc_sat, 1'b1);
`else
        check("wrap_sum", acc_sum, 33'h17FFFFFFD);
        check("wrap_flag", acc_sat, 1'b0);
`endif

        // Random traffic, occasionally ignoring start_hold and clearing
        for (int i = 0; i < 400; i++) begin
            cycle(bit'($urandom_range(0, 1)), $urandom, $urandom, $urandom,
                  bit'($urandom_range(0, 2) != 0), bit'($urandom_range(0, 31) == 0));
        end

        // Reset mid-operation: two entries buffered, sum of 50
        for (int i = 0; i < DEPTH + 1; i++) idle(1'b1);
        cycle(1'b1, 32'd0, 32'd0, 32'd50, 1'b0, 1'b1);
        cycle(1'b1, $urandom, $urandom, $urandom, 1'b1, 1'b0);
        cycle(1'b1, $urandom, $urandom, $urandom, 1'b0, 1'b0);
        check("pre_rst_sum", acc_sum, 33'd50);
        check("pre_rst_valid", bus.m_valid, 1'b1);
        bus.in_vld  = 1'b0;
        bus.m_ready = 1'b0;
        acc_clr     = 1'b0;
        #2 ap_rst_n = 1'b0;
        #1;
        check("mid_rst_valid", bus.m_valid, 1'b0);
        check("mid_rst_sum",   acc_sum,     '0);
        check("mid_rst_drop",  drop_err,    1'b0);
        check("mid_rst_cnt",   acc_cnt,     16'd0);
        q.delete();
        m_sum  = 0;
        m_cnt  = 0;
        m_drop = 0;
        m_sat  = 0;
        #2 ap_rst_n = 1'b1;
        @(posedge ap_clk);
        #1;
        check_state();
        cycle(1'b1, 32'd11, 32'd22, 32'd33, 1'b0, 1'b0);
        cycle(1'b0, '0, '0, '0, 1'b1, 1'b0);
        idle(1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
